// File: rtl/trace_frame_sched.sv
// trace_frame_sched: per-line trace scheduler for the ray tracer.
// Fires trace_start in hblank and commits host config in vblank only.
module trace_frame_sched #(
  parameter int HRES  = 640,
  parameter int VRES  = 480,
  parameter int HFULL = 800,
  parameter int VFULL = 525,
  parameter int CFG_W = 48,
  parameter logic [CFG_W-1:0] CFG_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       h,
  input  logic [9:0]       v,
  input  logic             trace_busy,
  input  logic             trace_done,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_commit,
  output logic [CFG_W-1:0] active_cfg,
  output logic             trace_start,
  output logic [9:0]       trace_line,
  output logic             tracing,
  output logic [7:0]       overrun_count
);

  localparam logic [0:0] S_WAIT  = 1'b0;
  localparam logic [0:0] S_TRACE = 1'b1;

  localparam logic [9:0] H_TRIG = 10'(HRES);
  localparam logic [9:0] V_VIS  = 10'(VRES);
  localparam logic [9:0] V_LVIS = 10'(VRES - 1);
  localparam logic [9:0] V_LAST = 10'(VFULL - 1);

  // Busy is informational only; the FSM tracks trace_done.
  logic unused_busy;
  assign unused_busy = trace_busy;

  logic [0:0]       state_q, state_d;
  logic             trace_start_q, trace_start_d;
  logic [9:0]       trace_line_q, trace_line_d;
  logic [7:0]       overrun_q, overrun_d;
  logic [CFG_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             commit_q, commit_d;
  logic [CFG_W-1:0] active_q, active_d;

  logic             trig;
  logic [9:0]       next_line;
  logic             in_vblank;
  logic             idle;
  logic             do_commit;
  logic             accept;

  // Line trigger decode and vblank window
  always_comb begin
    trig      = (h == H_TRIG) &&
                ((v == V_LAST) || (v < V_LVIS));
    next_line = (v == V_LAST) ? 10'd0 : v + 10'd1;
    in_vblank = (v >= V_VIS) && (v < V_LAST);
    // A done pulse frees the tracer for the next cycle.
    idle      = (state_q == S_WAIT) || trace_done;
    do_commit = pend_valid_q && in_vblank && idle;
    accept    = cfg_valid && !pend_valid_q;
  end

  // Trace scheduling FSM and overrun counter
  always_comb begin
    state_d       = state_q;
    trace_start_d = 1'b0;
    trace_line_d  = trace_line_q;
    overrun_d     = overrun_q;
    unique case (1'b1)
      (state_q == S_WAIT): begin
        if (trig) begin
          trace_start_d = 1'b1;
          trace_line_d  = next_line;
          state_d       = S_TRACE;
        end
      end
      default: begin
        if (trig && overrun_q != 8'hFF) begin
          overrun_d = overrun_q + 8'd1;
        end
        if (trace_done) begin
          state_d = S_WAIT;
        end
      end
    endcase
  end

  // One-deep config staging and vblank commit
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    commit_d     = 1'b0;
    active_d     = active_q;
    if (do_commit) begin
      active_d     = pend_q;
      commit_d     = 1'b1;
      pend_valid_d = 1'b0;
    end else if (accept) begin
      pend_d       = cfg_data;
      pend_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT;
      trace_start_q <= 1'b0;
      trace_line_q  <= 10'd0;
      overrun_q     <= 8'd0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      commit_q      <= 1'b0;
      active_q      <= CFG_RESET;
    end else begin
      state_q       <= state_d;
      trace_start_q <= trace_start_d;
      trace_line_q  <= trace_line_d;
      overrun_q     <= overrun_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      commit_q      <= commit_d;
      active_q      <= active_d;
    end
  end

  assign cfg_ready     = ~pend_valid_q;
  assign cfg_commit    = commit_q;
  assign active_cfg    = active_q;
  assign trace_start   = trace_start_q;
  assign trace_line    = trace_line_q;
  assign tracing       = (state_q == S_TRACE);
  assign overrun_count = overrun_q;

endmodule
